// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared definitions for the ALU arbiter slice: the ALU op codes
//            the arbiter may forward, a decode helper that flags supported
//            ops, and the arbiter FSM state encoding.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd15;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_NOR = 4'd12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // True only for op codes the ALU actually implements.
  function automatic logic op_supported(input logic [3:0] op);
    logic ok;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: ok = 1'b1;
      default:                                        ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-input round-robin arbiter. A lone request is granted
//            immediately; on contention the requester that was not granted
//            last wins. The last-grant pointer moves only when advance=1.
// Ports    : clk      in   clock, rising edge
//            reset    in   synchronous active-high reset
//            req      in   [1:0] request lines
//            advance  in   grant was consumed; record it as the last grant
//            gnt      out  [1:0] one-hot grant (zero when no request)
// Revision : 1.0  initial release
// ============================================================================
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // Resets to 1 so requester 0 wins the first contention.
  logic r_last;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = r_last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= 1'b1;
    end else if (advance) begin
      r_last <= gnt[1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Shares one 32-bit ALU between two requesters (0 = main datapath,
//            1 = auxiliary unit). Round-robin grant over a valid/ready
//            request channel, one EXEC cycle on the ALU, then a registered
//            response held until the consumer accepts it. Unsupported ops
//            never reach the ALU and are answered with rsp_err=1.
// Ports    : clk, reset                      clock / sync active-high reset
//            req_valid[1:0], req_ready[1:0]  request handshake per requester
//            req_op0/1, req_a0/1, req_b0/1   op code and operands
//            rsp_valid, rsp_ready            response handshake
//            rsp_id, rsp_data, rsp_zero,     response owner, result, zero
//            rsp_err                         flag, unsupported-op flag
//            alu_x, alu_y, alu_op            drive to the external ALU
//            alu_r, alu_zero                 result from the external ALU
// Revision : 1.0  initial release
// ============================================================================
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int         DATA_W  = 32,
  parameter logic [3:0] IDLE_OP = 4'd0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [3:0]        req_op0,
  input  logic [3:0]        req_op1,
  input  logic [DATA_W-1:0] req_a0,
  input  logic [DATA_W-1:0] req_a1,
  input  logic [DATA_W-1:0] req_b0,
  input  logic [DATA_W-1:0] req_b1,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_r,
  input  logic              alu_zero
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_op;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic              r_id;
  logic [1:0]        w_gnt;
  logic              w_take;
  logic              w_op_ok;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid),
    .advance (w_take),
    .gnt     (w_gnt)
  );

  assign w_op_ok   = op_supported(r_op);
  assign rsp_valid = (r_state == RESP);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grants are only offered in IDLE, so the handshake cycle in RESP never
  // overlaps with a new acceptance.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 2'b00;
    w_take      = 1'b0;
    alu_x       = '0;
    alu_y       = '0;
    alu_op      = IDLE_OP;
    case (r_state)
      IDLE: begin
        req_ready = w_gnt;
        w_take    = |(req_valid & w_gnt);
        if (w_take) begin
          w_state_nxt = EXEC;
        end
      end
      EXEC: begin
        alu_x = r_a;
        alu_y = r_b;
        // An unsupported op keeps the ALU on its idle op.
        if (w_op_ok) begin
          alu_op = r_op;
        end
        w_state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op     <= IDLE_OP;
      r_a      <= '0;
      r_b      <= '0;
      r_id     <= 1'b0;
      rsp_id   <= 1'b0;
      rsp_data <= '0;
      rsp_zero <= 1'b0;
      rsp_err  <= 1'b0;
    end else begin
      if (w_take) begin
        r_op <= w_gnt[1] ? req_op1 : req_op0;
        r_a  <= w_gnt[1] ? req_a1  : req_a0;
        r_b  <= w_gnt[1] ? req_b1  : req_b0;
        r_id <= w_gnt[1];
      end
      // Response fields change only here, so they stay frozen through RESP.
      if (r_state == EXEC) begin
        rsp_id   <= r_id;
        rsp_data <= w_op_ok ? alu_r : '0;
        rsp_zero <= w_op_ok & alu_zero;
        rsp_err  <= ~w_op_ok;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Self-checking bench for alu_arbiter with a behavioural ALU.
//            Stimulus pushes hand-computed responses into a scoreboard queue;
//            a monitor pops and compares on every response handshake.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [3:0]  req_op0, req_op1;
  logic [31:0] req_a0, req_a1, req_b0, req_b1;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
  logic [31:0] rsp_data;
  logic [31:0] alu_x, alu_y, alu_r;
  logic [3:0]  alu_op;
  logic        alu_zero;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(32), .IDLE_OP(4'd0)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_a1(req_a1),
    .req_b0(req_b0), .req_b1(req_b1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op),
    .alu_r(alu_r), .alu_zero(alu_zero)
  );

  // Behavioural ALU sitting beside the arbiter.
  always_comb begin
    alu_r = 32'd0;
    case (alu_op)
      4'd0:  alu_r = alu_x & alu_y;
      4'd1:  alu_r = alu_x | alu_y;
      4'd15: alu_r = alu_x + alu_y;
      4'd6:  alu_r = alu_x - alu_y;
      4'd7:  alu_r = (alu_x < alu_y) ? 32'd1 : 32'd0;
      4'd12: alu_r = ~(alu_x | alu_y);
      default: alu_r = 32'd0;
    endcase
  end
  assign alu_zero = (alu_r == 32'd0);

  typedef struct packed {
    logic        id;
    logic [31:0] data;
    logic        zero;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t m_exp;
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted response is compared to the oldest
  // expectation.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected: got id=%0d data=%0h, expected no response", rsp_id, rsp_data);
      end else begin
        m_exp = sb.pop_front();
        chk("rsp_id",   32'(rsp_id),   32'(m_exp.id));
        chk("rsp_data", rsp_data,      m_exp.data);
        chk("rsp_zero", 32'(rsp_zero), 32'(m_exp.zero));
        chk("rsp_err",  32'(rsp_err),  32'(m_exp.err));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic p, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (p == 1'b0) begin
      req_op0 = op; req_a0 = a; req_b0 = b;
    end else begin
      req_op1 = op; req_a1 = a; req_b1 = b;
    end
    req_valid[p] = 1'b1;
  endtask

  task automatic expect_rsp(input logic id, input logic [31:0] d, input logic z, input logic e);
    sb.push_back(exp_t'{id, d, z, e});
  endtask

  // Wait (bounded) for requester p to be granted, then let the transfer edge
  // pass and drop its valid.
  task automatic wait_grant(input logic p, input string name);
    int n = 0;
    @(negedge clk);
    while (req_ready[p] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(req_ready[p]), 32'd1);
    step();
    req_valid[p] = 1'b0;
  endtask

  // Wait (bounded) for a response handshake and step past it.
  task automatic wait_rsp(input string name);
    int n = 0;
    while (!(rsp_valid === 1'b1 && rsp_ready === 1'b1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(rsp_valid & rsp_ready), 32'd1);
    step();
  endtask

  // Single request with latency and ALU-drive checks.
  task automatic send(input logic p, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] exec_op, input logic [31:0] d, input logic z, input logic e,
                      input string tag);
    drive(p, op, a, b);
    expect_rsp(p, d, z, e);
    wait_grant(p, {tag, "_grant"});
    @(negedge clk);
    chk({tag, "_exec_op"},    32'(alu_op),    32'(exec_op));
    chk({tag, "_exec_x"},     alu_x,          a);
    chk({tag, "_exec_y"},     alu_y,          b);
    chk({tag, "_exec_valid"}, 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_n2_valid"},   32'(rsp_valid), 32'd1);
    chk({tag, "_resp_op"},    32'(alu_op),    32'd0);
    wait_rsp({tag, "_rsp"});
  endtask

  // Both requesters already driven; f must win first, the other next.
  task automatic pair(input logic f, input string tag);
    @(negedge clk);
    chk({tag, "_first_grant"}, 32'(req_ready), f ? 32'd2 : 32'd1);
    step();
    req_valid[f] = 1'b0;
    @(negedge clk);
    chk({tag, "_busy_ready"}, 32'(req_ready), 32'd0);
    wait_rsp({tag, "_rsp_first"});
    @(negedge clk);
    chk({tag, "_second_grant"}, 32'(req_ready), f ? 32'd1 : 32'd2);
    step();
    req_valid[~f] = 1'b0;
    wait_rsp({tag, "_rsp_second"});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_valid = 2'b00; rsp_ready = 1'b1;
    req_op0 = 4'd0; req_op1 = 4'd0;
    req_a0 = 32'd0; req_a1 = 32'd0; req_b0 = 32'd0; req_b1 = 32'd0;
    repeat (3) step();
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id",    32'(rsp_id),    32'd0);
    chk("rst_rsp_data",  rsp_data,       32'd0);
    chk("rst_rsp_zero",  32'(rsp_zero),  32'd0);
    chk("rst_rsp_err",   32'(rsp_err),   32'd0);
    chk("rst_alu_op",    32'(alu_op),    32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    step();

    // ADD / SUB / SLT
    send(1'b0, 4'd15, 32'd5, 32'd7, 4'd15, 32'd12, 1'b0, 1'b0, "add");
    send(1'b1, 4'd6,  32'd9, 32'd9, 4'd6,  32'd0,  1'b1, 1'b0, "sub");
    send(1'b1, 4'd7,  32'hFFFFFFFF, 32'd1, 4'd7, 32'd0, 1'b1, 1'b0, "slt");

    // Contention straight after reset: requester 0 first
    do_reset();
    drive(1'b0, 4'd15, 32'd1, 32'd1);
    drive(1'b1, 4'd1,  32'd4, 32'd2);
    expect_rsp(1'b0, 32'd2, 1'b0, 1'b0);
    expect_rsp(1'b1, 32'd6, 1'b0, 1'b0);
    pair(1'b0, "pair1");

    // Unsupported op; ALU would give 3 for AND 3,3, but capture is forced to 0
    send(1'b0, 4'd3, 32'd3, 32'd3, 4'd0, 32'd0, 1'b0, 1'b1, "unsup");

    // Second pair after requester 0 was served last: requester 1 first
    drive(1'b0, 4'd6, 32'd20, 32'd5);
    drive(1'b1, 4'd0, 32'd12, 32'd10);
    expect_rsp(1'b1, 32'd8,  1'b0, 1'b0);
    expect_rsp(1'b0, 32'd15, 1'b0, 1'b0);
    pair(1'b1, "pair2");

    // Backpressure with requester 1 waiting
    rsp_ready = 1'b0;
    drive(1'b0, 4'd15, 32'd10, 32'd20);
    expect_rsp(1'b0, 32'd30, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_grant0", 32'(req_ready), 32'd1);
    step();
    req_valid[0] = 1'b0;
    drive(1'b1, 4'd6, 32'd50, 32'd8);
    expect_rsp(1'b1, 32'd42, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_exec_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
      chk("bp_hold_id",    32'(rsp_id),    32'd0);
      chk("bp_hold_data",  rsp_data,       32'd30);
      chk("bp_hold_err",   32'(rsp_err),   32'd0);
      chk("bp_hold_ready", 32'(req_ready), 32'd0);
    end
    step();
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("bp_grant1_next", 32'(req_ready), 32'd2);
    step();
    req_valid[1] = 1'b0;
    wait_rsp("bp_rsp1");

    // Reset during EXEC of NOR 0,0 with requester 1 held across reset
    drive(1'b0, 4'd12, 32'd0, 32'd0);
    @(negedge clk);
    chk("rx_grant0", 32'(req_ready), 32'd1);
    step();
    req_valid[0] = 1'b0;
    drive(1'b1, 4'd15, 32'd100, 32'd23);
    expect_rsp(1'b1, 32'd123, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("rx_exec_op", 32'(alu_op), 32'd12);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rx_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rx_rsp_id",    32'(rsp_id),    32'd0);
    chk("rx_rsp_data",  rsp_data,       32'd0);
    chk("rx_rsp_zero",  32'(rsp_zero),  32'd0);
    chk("rx_rsp_err",   32'(rsp_err),   32'd0);
    chk("rx_alu_x",     alu_x,          32'd0);
    chk("rx_alu_y",     alu_y,          32'd0);
    chk("rx_alu_op",    32'(alu_op),    32'd0);
    chk("rx_held_grant", 32'(req_ready), 32'd2);
    step();
    req_valid[1] = 1'b0;
    wait_rsp("rx_held_rsp");

    repeat (3) step();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 32-bit ALU between two requesters: port 0 is the main datapath, port 1 is an auxiliary unit such as a branch/compare helper.
- Round-robin grant, valid/ready request handshake and a registered response channel with backpressure.
- Drives the ALU operand and op inputs, and captures its result and zero flag.
- Rejects op codes the ALU does not implement, so the ALU is never driven with an undefined op.

Parameters:
- DATA_W, 32, operand/result width; fixed to the ALU width.
- IDLE_OP, 4'd0, op driven to the ALU whenever no operation is executing.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  2  per-requester request valid; bit i = requester i.
- req_ready  out  2  per-requester accept; a request transfers when valid and ready are both high.
- req_op0, req_op1  in  4  ALU op code per requester.
- req_a0, req_a1  in  DATA_W  operand X per requester.
- req_b0, req_b1  in  DATA_W  operand Y per requester.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  requester that owns the response.
- rsp_data  out  DATA_W  ALU result.
- rsp_zero  out  1  ALU zero flag.
- rsp_err  out  1  op code was not supported.
- alu_x, alu_y  out  DATA_W  to ALU X/Y.
- alu_op  out  4  to ALU op.
- alu_r  in  DATA_W  from ALU r.
- alu_zero  in  1  from ALU zero.

Behaviour:
- Supported ops: 0 AND, 1 OR, 15 ADD, 6 SUB, 7 SLT, 12 NOR.
- SLT is an unsigned compare, as the ALU implements it.
- FSM states are IDLE, EXEC and RESP.
- IDLE:
  - The arbiter picks one valid requester and drives req_ready for that requester only. req_ready is combinational from req_valid and the state, and is 0 in every state except IDLE.
  - On transfer, the block latches op, a, b and id into internal registers and moves to EXEC.
- EXEC (exactly one cycle):
  - alu_x, alu_y and alu_op are driven from the latched registers.
  - At the end of the cycle, alu_r and alu_zero are captured into rsp_data and rsp_zero; then go to RESP.
- Unsupported op (any op not in the list above):
  - alu_op stays at IDLE_OP during EXEC.
  - Capture is rsp_err=1, rsp_data=0, rsp_zero=0.
  - Latency is unchanged.
- RESP:
  - rsp_valid=1, with rsp_id, rsp_data, rsp_zero and rsp_err held stable until rsp_ready=1.
  - On the handshake cycle the FSM returns to IDLE; no new grant is made in that same cycle.
- Latency: request accepted in cycle N, rsp_valid high in cycle N+2. Minimum issue interval is 3 cycles.
- Outside EXEC, alu_x and alu_y are 0 and alu_op is IDLE_OP.
- Arbitration:
  - A last-grant pointer is updated on every accepted request.
  - If both requesters are valid, grant the one not granted last.
  - A single valid requester is granted immediately.
- Requester rules: a requester must hold valid, op and operands stable until accepted. The block latches on transfer, so later changes have no effect.
- Reset values: state=IDLE, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_zero=0, rsp_err=0, alu_x=0, alu_y=0, alu_op=IDLE_OP. The last-grant pointer resets to 1, so requester 0 wins the first contention.
- Reset during EXEC or RESP: the in-flight operation is discarded with no response. rsp_valid is 0 in the cycle after the reset edge.
- Requests held across reset are re-arbitrated from IDLE.

Decomposition:
- Shared package alu_pkg holds:
  - op constants OP_AND=0, OP_OR=1, OP_ADD=15, OP_SUB=6, OP_SLT=7, OP_NOR=12;
  - function op_supported(op);
  - FSM state encoding IDLE/EXEC/RESP.
- One sub-module, rr_arb2: 2-input round-robin arbiter.
  - Inputs: clk, reset, req[1:0], advance.
  - Output: one-hot gnt[1:0].
  - The pointer updates only when advance=1.
- The ALU itself is instantiated alongside the arbiter, not inside it.

Test Plan:
- ADD: req0 op=15, a=5, b=7, rsp_ready=1 → cycle N+2: rsp_valid=1, rsp_id=0, rsp_data=12, rsp_zero=0, rsp_err=0. alu_op=15 only during the EXEC cycle.
- SUB and SLT on requester 1:
  - op=6, a=9, b=9 → rsp_data=0, rsp_zero=1, rsp_id=1.
  - op=7, a=32'hFFFFFFFF, b=1 → rsp_data=0, rsp_zero=1 (unsigned compare).
- Contention: both valid after reset with ADD 1+1 and OR 4|2 → req0 served first (data 2), then req1 (data 6). A second simultaneous pair is served req1 first. No requester waits for more than one other operation.
- Unsupported op: req0 op=3 → rsp_err=1, rsp_data=0, rsp_zero=0 at N+2; alu_op stays 0 throughout.
- Backpressure: rsp_ready=0 for 4 cycles during RESP, with req1 valid → rsp fields stable and req_ready=2'b00. The handshake happens on the cycle rsp_ready rises, and req1 is granted the following cycle.
- Reset: assert reset in EXEC of NOR 0,0 → no response emitted; all outputs at reset values next cycle. A request held across reset completes normally after reset.
